weight_loader: RTL and testbench
================================

# weight_loader

Weight-load sequencer for the weight-stationary systolic array. It accepts one full weight tile (N rows × M columns of signed 8-bit weights) over a valid/ready stream and buffers it locally. It then streams the tile down the array's psum chain, bottom row first, so that every PE row captures its own weights on the same clock edge. It drives the top-row `in_psum` inputs and the broadcast `en_weight_pass` / per-row `en_weight_capture` controls consumed by the PE grid.

## Interface
- `N`, default 4: array rows (≥2).
- `M`, default 4: array columns (≥1).
- `clk`, input, 1: the block's one clock; everything is rising-edge.
- `reset`, input, 1: asynchronous, active-high.
- `start`, input, 1: begin a load; sampled only in IDLE.
- `w_valid`, input, 1: weight row valid.
- `w_data`, input, M*8: one weight row, signed; column c is at bits [8c+7:8c].
- `w_ready`, output, 1: row accepted when `w_valid && w_ready`.
- `psum_inj`, output, M*16: drives top-row `in_psum`; column c is at bits [16c+15:16c].
- `en_weight_pass`, output, 1: broadcast to all PEs.
- `en_weight_capture`, output, N: bit r goes to every PE in row r.
- `busy`, output, 1: high whenever the state is not IDLE.
- `done`, output, 1: one-cycle pulse when the load completes.

## Operation
- FSM states: IDLE, FILL, STREAM, DONE.
- IDLE:
  - `w_ready=0`.
  - `start` → FILL; row counter cleared.
- FILL:
  - `w_ready=1`.
  - Each handshake writes `w_data` into buffer slot `cnt` (the row arriving k-th is weight row k, row 0 = top), then increments `cnt`.
  - The handshake on row N-1 → STREAM; counter cleared.
  - Stalls (`w_valid=0`) are allowed indefinitely. The array is untouched during FILL.
- STREAM, exactly N cycles, k=0..N-1:
  - `en_weight_pass=1`.
  - `psum_inj` column c = sign-extend(buf[N-1-k][c]) to 16 bits.
  - `en_weight_capture` is all-ones only at k=N-1 and zero otherwise.
  - The cycle after k=N-1 → DONE.
- DONE, one cycle:
  - `done=1`, `en_weight_pass=0`.
  - Next cycle → IDLE.
- `start` outside IDLE is ignored.
- `w_valid` outside FILL is ignored and not accepted.
- All outputs are registered (Moore-style; values are functions of state/counter registers only).

## Timing
- Reset value of every output is 0: `w_ready`, `psum_inj`, `en_weight_pass`, `en_weight_capture`, `busy`, `done`.
- Async reset mid-FILL or mid-STREAM returns immediately to IDLE and zeroes the outputs. Buffer contents are don't-care, and the partial tile is discarded.
- `start` high at edge t gives `w_ready=1` from cycle t+1.
- The last FILL handshake at edge f means STREAM k=0 occupies cycle f+1, and capture occurs in cycle f+N.
- Alignment rule: with a 1-cycle PE pass latency, row r sees injection k at cycle k+r. Row r's weights are injected at k=N-1-r, so every row holds its own weights at k=N-1.
- `done` appears in cycle f+N+1 and `busy` falls in cycle f+N+2.
- Minimum load is 1 (start) + N (fill) + N (stream) + 1 (done) cycles.
- `en_weight_pass` is never deasserted inside STREAM; the psum chain has no stall.
- After `done`, PE `out_psum` registers still hold weight values. They flush after N compute cycles, and downstream accumulation must discard them.

## Configuration
- `WEIGHT_LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` [15:0]: the wrap-around sum of all N*M sign-extended weights of the most recently completed load.
  - It is updated on the edge entering DONE and stable while `done` is high.
  - Reset value is 0, and an aborted load does not update it.
- Undefined: the port and the accumulator are absent, and behaviour is otherwise identical.

## Structure
- Shared `tpu_pkg` holds:
  - `ACT_W=8` and `PSUM_W=16`.
  - The `wl_state_e` enum (IDLE, FILL, STREAM, DONE).
  - The `weight_t` signed 8-bit and `psum_t` signed 16-bit typedefs.
- Sub-module `weight_row_buffer`: an N-entry × M*8 register file with one write port (FILL) and one read port (STREAM index N-1-k), no reset.
- The top level holds the FSM, counter, output registers and the optional checksum.

## Test plan
- Reset, N=M=4: all outputs 0. Assert `reset` mid-STREAM → outputs 0 in the same cycle and the FSM returns to IDLE. A `start` after reset completes a normal load.
- Tile rows 0..3 = {1,2,3,4}, {-1,-2,-3,-4}, {127,-128,0,5}, {9,9,9,9}, no stalls:
  - `psum_inj` sequence is row3, row2, row1, row0, with -128 appearing as 0xFF80.
  - Capture is 4'b1111 only on the 4th STREAM cycle.
  - A 4×4 PE-grid model holds exactly the tile afterwards.
- Random `w_valid` gaps during FILL (up to 5 cycles): the captured tile is identical to the no-stall case, and STREAM starts exactly 1 cycle after the 4th handshake.
- `start` pulsed during FILL/STREAM/DONE, and `w_valid` held high in IDLE/STREAM: no extra handshakes and no state change; `done` pulses exactly once per load.
- Back-to-back loads (`start` in the cycle after `busy` falls) with different tiles: the second tile is captured correctly, and `done` is 1 cycle wide each time.
- With `WEIGHT_LOADER_CHECKSUM_EN`: an all-127 tile → `checksum=2032`. Next, an all -128 tile → 0xF800. A reset-aborted third load leaves `checksum` at 0 (reset) and not at a partial value.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and widths for the systolic-array blocks.
package tpu_pkg;

  localparam int ACT_W  = 8;
  localparam int PSUM_W = 16;

  typedef logic signed [ACT_W-1:0]  weight_t;
  typedef logic signed [PSUM_W-1:0] psum_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } wl_state_e;

  // Sign-extend one weight to the psum width.
  function automatic psum_t sext(input weight_t w);
    return psum_t'(w);
  endfunction

endpackage

// File: rtl/weight_row_buffer.sv
// N-entry weight tile buffer: one write port used while filling, one
// asynchronous read port used while streaming.
module weight_row_buffer
  import tpu_pkg::*;
#(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [M*ACT_W-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [M*ACT_W-1:0] rd_data
);

  logic [M*ACT_W-1:0] mem [N];

  // Row write on each accepted handshake.
  // NOTE: storage arrays carry no reset; every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/weight_loader.sv
// Weight-load sequencer: buffers one N x M weight tile, then streams it
// bottom row first down the psum chain so every PE row captures its own
// weights on the same edge.
// Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to add the 16-bit
// wrap-around `checksum` output of the last completed tile.
module weight_loader
  import tpu_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                w_valid,
  input  logic [M*ACT_W-1:0]  w_data,
  output logic                w_ready,
  output logic [M*PSUM_W-1:0] psum_inj,
  output logic                en_weight_pass,
  output logic [N-1:0]        en_weight_capture,
  output logic                busy,
  output logic                done
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]         checksum
`endif
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  wl_state_e          state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               hs;
  logic [CW-1:0]      rd_idx;
  logic [M*ACT_W-1:0] rd_data;
  logic [M*ACT_W-1:0] row_src;

  logic                w_ready_n, pass_n, busy_n, done_n;
  logic [N-1:0]        capture_n;
  logic [M*PSUM_W-1:0] psum_n;

  // w_ready is high exactly in FILL, so this is the FILL handshake.
  assign hs = w_valid & w_ready;

  // The read index follows the next counter so psum_inj can be registered.
  assign rd_idx = LAST - cnt_n;

  // Entering STREAM, slot N-1 is written on the same edge; forward it.
  assign row_src = (state == FILL) ? w_data : rd_data;

  weight_row_buffer #(
    .N     (N),
    .M     (M),
    .IDX_W (CW)
  ) u_buf (
    .clk     (clk),
    .we      (hs),
    .wr_idx  (cnt),
    .wr_data (w_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // State and row/stream counter register.
  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and counter logic.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = FILL;
          cnt_n   = '0;
        end
      end
      FILL: begin
        if (hs) begin
          if (cnt == LAST) begin
            state_n = STREAM;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      STREAM: begin
        if (cnt == LAST) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Next output values, decoded from the next state/counter.
  always_comb begin
    w_ready_n = (state_n == FILL);
    busy_n    = (state_n != IDLE);
    pass_n    = (state_n == STREAM);
    done_n    = (state_n == DONE);
    capture_n = (state_n == STREAM && cnt_n == LAST) ? '1 : '0;
    psum_n    = '0;
    if (state_n == STREAM) begin
      for (int c = 0; c < M; c++) begin
        psum_n[c*PSUM_W +: PSUM_W] = sext(row_src[c*ACT_W +: ACT_W]);
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ready           <= 1'b0;
      psum_inj          <= '0;
      en_weight_pass    <= 1'b0;
      en_weight_capture <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      w_ready           <= w_ready_n;
      psum_inj          <= psum_n;
      en_weight_pass    <= pass_n;
      en_weight_capture <= capture_n;
      busy              <= busy_n;
      done              <= done_n;
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  psum_t acc;
  psum_t row_sum;

  // Sum of the sign-extended weights in the incoming row.
  always_comb begin
    row_sum = '0;
    for (int c = 0; c < M; c++) begin
      row_sum = row_sum + sext(w_data[c*ACT_W +: ACT_W]);
    end
  end

  // Running tile sum; published only when a load reaches DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      checksum <= '0;
    end else begin
      if (state == IDLE && start) acc <= '0;
      else if (hs)                acc <= acc + row_sum;
      if (state == STREAM && state_n == DONE) checksum <= acc;
    end
  end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader (N=M=4) with a PE-grid model that
// follows the psum chain and captures weights per row.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        w_valid;
  logic [31:0] w_data;
  logic        w_ready;
  logic [63:0] psum_inj;
  logic        en_weight_pass;
  logic [3:0]  en_weight_capture;
  logic        busy;
  logic        done;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
  logic [15:0] ck_at_done;
`endif

  int checks = 0;
  int errors = 0;

  weight_loader #(.N(4), .M(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .w_valid           (w_valid),
    .w_data            (w_data),
    .w_ready           (w_ready),
    .psum_inj          (psum_inj),
    .en_weight_pass    (en_weight_pass),
    .en_weight_capture (en_weight_capture),
    .busy              (busy),
    .done              (done)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    .checksum          (checksum)
`endif
  );

  always #5 clk = ~clk;

  // PE grid model: pipe[r] is row r's out_psum, grid[r] its captured weights.
  logic [3:0][63:0] pipe;
  logic [3:0][63:0] grid;
  logic             grid_clr;
  int               hs_cnt   = 0;
  int               done_cnt = 0;

  always @(negedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (grid_clr) grid[r] <= '0;
      else if (en_weight_capture[r]) grid[r] <= (r == 0) ? psum_inj : pipe[r-1];
      if (en_weight_pass) pipe[r] <= (r == 0) ? psum_inj : pipe[r-1];
    end
    if (done) done_cnt++;
    if (w_valid && w_ready) hs_cnt++;
  end

  // Tile A rows 0..3: {1,2,3,4} {-1,-2,-3,-4} {127,-128,0,5} {9,9,9,9}
  localparam logic [3:0][31:0] TILE_A = {32'h09090909, 32'h0500807F, 32'hFCFDFEFF, 32'h04030201};
  // Expected psum_inj for k=0..3 (rows 3,2,1,0)
  localparam logic [3:0][63:0] PSUM_A = {64'h0004_0003_0002_0001, 64'hFFFC_FFFD_FFFE_FFFF,
                                         64'h0005_0000_FF80_007F, 64'h0009_0009_0009_0009};
  // Tile B rows 0..3: {-1 x4} {0 x4} {1,-1,2,-2} {64,32,16,8}
  localparam logic [3:0][31:0] TILE_B = {32'h08102040, 32'hFE02FF01, 32'h00000000, 32'hFFFFFFFF};
  localparam logic [3:0][63:0] PSUM_B = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                                         64'hFFFE_0002_FFFF_0001, 64'h0008_0010_0020_0040};
  localparam logic [3:0][31:0] TILE_P = {4{32'h7F7F7F7F}};
  localparam logic [3:0][63:0] PSUM_P = {4{64'h007F_007F_007F_007F}};
  localparam logic [3:0][31:0] TILE_N = {4{32'h80808080}};
  localparam logic [3:0][63:0] PSUM_N = {4{64'hFF80_FF80_FF80_FF80}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full load with inline checks; optional random FILL gaps and
  // out-of-phase start/w_valid noise.
  task automatic load_tile(input logic [3:0][31:0] rows, input logic [3:0][63:0] exp_psum,
                           input int max_gap, input bit noise);
    int hs0, dn0, gap;
    hs0 = hs_cnt;
    dn0 = done_cnt;
    start = 1'b1;
    grid_clr = 1'b1;
    step();
    start = 1'b0;
    grid_clr = 1'b0;
    checks++;
    if (w_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_to_fill: w_ready=%b busy=%b, required 1 1", w_ready, busy);
    end
    for (int k = 0; k < 4; k++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        w_valid = 1'b0;
        start = noise;
        step();
        start = 1'b0;
      end
      w_valid = 1'b1;
      w_data = rows[k];
      start = noise;
      step();
      w_valid = 1'b0;
      w_data = '0;
      start = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (en_weight_pass !== 1'b1 || psum_inj !== exp_psum[k] ||
          en_weight_capture !== ((k == 3) ? 4'hF : 4'h0) || w_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stream_k%0d: pass=%b psum=%h cap=%b ready=%b busy=%b, required 1 %h %b 0 1",
                 k, en_weight_pass, psum_inj, en_weight_capture, w_ready, busy,
                 exp_psum[k], (k == 3) ? 4'hF : 4'h0);
      end
      if (noise) begin
        start = 1'b1;
        w_valid = 1'b1;
        w_data = 32'hDEADBEEF;
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || en_weight_pass !== 1'b0 || en_weight_capture !== 4'h0 ||
        psum_inj !== 64'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle: done=%b pass=%b cap=%b psum=%h busy=%b, required 1 0 0 0 1",
               done, en_weight_pass, en_weight_capture, psum_inj, busy);
    end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ck_at_done = checksum;
`endif
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || w_ready !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: busy=%b done=%b ready=%b, required 0 0 0", busy, done, w_ready);
    end
    if (noise) begin
      repeat (3) step();
      checks++;
      if (busy !== 1'b0 || w_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid_ignored: busy=%b ready=%b, required 0 0", busy, w_ready);
      end
      w_valid = 1'b0;
      w_data = '0;
    end
    checks++;
    if (hs_cnt - hs0 != 4 || done_cnt - dn0 != 1) begin
      errors++;
      $display("FAIL counts: handshakes=%0d done_cycles=%0d, required 4 1", hs_cnt - hs0, done_cnt - dn0);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (grid[r] !== exp_psum[3-r]) begin
        errors++;
        $display("FAIL grid_row%0d: got %h, required %h", r, grid[r], exp_psum[3-r]);
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (w_ready !== 1'b0 || psum_inj !== 64'h0 || en_weight_pass !== 1'b0 ||
        en_weight_capture !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%b psum=%h pass=%b cap=%b busy=%b done=%b, required all 0",
               tag, w_ready, psum_inj, en_weight_pass, en_weight_capture, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    w_valid = 1'b0;
    w_data = '0;
    grid_clr = 1'b0;
    #3;
    check_zero_outputs("reset_values");
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 16'h0) begin
      errors++;
      $display("FAIL reset_checksum: got %h, required 0000", checksum);
    end
`endif
    step();
    step();
    reset = 1'b0;
    step();
    check_zero_outputs("idle_after_reset");
  endtask

  task automatic test_basic();
    load_tile(TILE_A, PSUM_A, 0, 1'b0);
  endtask

  task automatic test_stalls();
    load_tile(TILE_A, PSUM_A, 5, 1'b1);
    load_tile(TILE_B, PSUM_B, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    load_tile(TILE_B, PSUM_B, 0, 1'b0);
    load_tile(TILE_A, PSUM_A, 0, 1'b0);
  endtask

  task automatic test_reset_mid_stream();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_valid = 1'b1;
      w_data = TILE_A[k];
      step();
    end
    w_valid = 1'b0;
    step();
    checks++;
    if (en_weight_pass !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort_stream: pass=%b, required 1", en_weight_pass);
    end
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset_mid_stream");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check_zero_outputs("idle_after_abort");
    load_tile(TILE_A, PSUM_A, 0, 1'b0);
  endtask

  task automatic test_extremes();
    load_tile(TILE_P, PSUM_P, 0, 1'b0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    checks++;
    if (ck_at_done !== 16'd2032 || checksum !== 16'd2032) begin
      errors++;
      $display("FAIL checksum_all127: at_done=%0d after=%0d, required 2032", ck_at_done, checksum);
    end
`endif
    load_tile(TILE_N, PSUM_N, 0, 1'b0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    checks++;
    if (ck_at_done !== 16'hF800 || checksum !== 16'hF800) begin
      errors++;
      $display("FAIL checksum_all_m128: at_done=%h after=%h, required F800", ck_at_done, checksum);
    end
`endif
  endtask

  task automatic test_abort_fill();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w_valid = 1'b1;
      w_data = TILE_P[k];
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    w_valid = 1'b0;
    check_zero_outputs("async_reset_mid_fill");
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 16'h0) begin
      errors++;
      $display("FAIL checksum_abort: got %h, required 0000", checksum);
    end
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check_zero_outputs("idle_after_fill_abort");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_back_to_back();
    test_reset_mid_stream();
    test_extremes();
    test_abort_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
